// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: one state register plus decoded datapath enables.
// Outputs are decoded from the current state (and mem_ready in FETCH) and held at zero during reset.
module multicycle_control #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        HALT      = 4'd15
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    stateT stateReg;
    stateT stateNext;

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            FETCH:     stateNext = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: stateNext = MEM_ADDR;
                    OP_RTYPE:     stateNext = R_EXEC;
                    OP_BEQ:       stateNext = BRANCH;
                    OP_J:         stateNext = JUMP;
                    OP_ADDI:      stateNext = ADDI_EXEC;
                    default:      stateNext = ILLEGAL_HALT ? HALT : FETCH;
                endcase
            end
            // Only lw/sw reach here; anything but sw is treated as a load.
            MEM_ADDR:  stateNext = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  stateNext = mem_ready ? MEM_WB : MEM_READ;
            MEM_WB:    stateNext = FETCH;
            MEM_WRITE: stateNext = mem_ready ? FETCH : MEM_WRITE;
            R_EXEC:    stateNext = R_WB;
            R_WB:      stateNext = FETCH;
            BRANCH:    stateNext = FETCH;
            JUMP:      stateNext = FETCH;
            ADDI_EXEC: stateNext = ADDI_WB;
            ADDI_WB:   stateNext = FETCH;
            HALT:      stateNext = HALT;
            default:   stateNext = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= FETCH;
        end else begin
            stateReg <= stateNext;
        end
    end

    assign state = stateReg;

    // Gating on reset keeps every enable low for the whole reset pulse, even though state reads FETCH.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        if (!reset) begin
            case (stateReg)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                R_WB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                ADDI_WB: begin
                    reg_write = 1'b1;
                end
                HALT: begin
                    illegal = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected states are queued per instruction,
// then popped and compared (state and all outputs) against a halting and a non-halting instance.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;

    logic       hPcWrite, hPcWriteCond, hIOrD, hMemRead, hMemWrite, hMemToReg;
    logic       hIrWrite, hRegDst, hRegWrite, hAluSrcA, hIllegal;
    logic [1:0] hAluSrcB, hAluOp, hPcSource;
    logic [3:0] hState;
    logic       sPcWrite, sPcWriteCond, sIOrD, sMemRead, sMemWrite, sMemToReg;
    logic       sIrWrite, sRegDst, sRegWrite, sAluSrcA, sIllegal;
    logic [1:0] sAluSrcB, sAluOp, sPcSource;
    logic [3:0] sState;

    multicycle_control #(.ILLEGAL_HALT(1'b1)) dutHalt (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(hPcWrite), .pc_write_cond(hPcWriteCond), .i_or_d(hIOrD),
        .mem_read(hMemRead), .mem_write(hMemWrite), .mem_to_reg(hMemToReg),
        .ir_write(hIrWrite), .reg_dst(hRegDst), .reg_write(hRegWrite),
        .alu_src_a(hAluSrcA), .alu_src_b(hAluSrcB), .alu_op(hAluOp),
        .pc_source(hPcSource), .state(hState), .illegal(hIllegal)
    );

    multicycle_control #(.ILLEGAL_HALT(1'b0)) dutSoft (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(sPcWrite), .pc_write_cond(sPcWriteCond), .i_or_d(sIOrD),
        .mem_read(sMemRead), .mem_write(sMemWrite), .mem_to_reg(sMemToReg),
        .ir_write(sIrWrite), .reg_dst(sRegDst), .reg_write(sRegWrite),
        .alu_src_a(sAluSrcA), .alu_src_b(sAluSrcB), .alu_op(sAluOp),
        .pc_source(sPcSource), .state(sState), .illegal(sIllegal)
    );

    always #5 clk = ~clk;

    wire [16:0] outsHalt = {hPcWrite, hPcWriteCond, hIOrD, hMemRead, hMemWrite, hMemToReg,
                            hIrWrite, hRegDst, hRegWrite, hAluSrcA, hAluSrcB, hAluOp,
                            hPcSource, hIllegal};
    wire [16:0] outsSoft = {sPcWrite, sPcWriteCond, sIOrD, sMemRead, sMemWrite, sMemToReg,
                            sIrWrite, sRegDst, sRegWrite, sAluSrcA, sAluSrcB, sAluOp,
                            sPcSource, sIllegal};

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] softSt;
        logic       mr;
    } StepT;

    StepT sb[$];
    int total = 0;
    int bad = 0;

    // Expected output vector per state, taken from the state table.
    function automatic logic [16:0] expOuts(input logic [3:0] st, input logic mr);
        logic pw, pwc, iod, mrd, mwr, m2r, irw, rdst, rw, asa, ill;
        logic [1:0] asb, aop, psrc;
        pw = 0; pwc = 0; iod = 0; mrd = 0; mwr = 0; m2r = 0; irw = 0;
        rdst = 0; rw = 0; asa = 0; ill = 0; asb = 0; aop = 0; psrc = 0;
        case (st)
            4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
            4'd1:  asb = 2'b11;
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iod = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin mwr = 1; iod = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rdst = 1; rw = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            4'd9:  begin pw = 1; psrc = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
            4'd15: ill = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mrd, mwr, m2r, irw, rdst, rw, asa, asb, aop, psrc, ill};
    endfunction

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [3:0] softSt, input logic mr);
        sb.push_back('{st: st, softSt: softSt, mr: mr});
    endtask

    // Entered just after a rising edge; each step drives mem_ready, checks mid-cycle, advances.
    task automatic runQueue(input string name);
        int n = 0;
        while (sb.size() > 0) begin
            StepT s = sb.pop_front();
            mem_ready = s.mr;
            @(negedge clk);
            check({name, ".stateH"}, {13'd0, hState}, {13'd0, s.st});
            check({name, ".outsH"}, outsHalt, expOuts(s.st, s.mr));
            check({name, ".stateS"}, {13'd0, sState}, {13'd0, s.softSt});
            check({name, ".outsS"}, outsSoft, expOuts(s.softSt, s.mr));
            n++;
            @(posedge clk);
            #1;
        end
        $display("txn %s cycles=%0d", name, n);
    endtask

    task automatic runInstr(input string name, input logic [5:0] op,
                            input int fetchStall, input int memStall);
        opcode = op;
        repeat (fetchStall) push(4'd0, 4'd0, 1'b0);
        push(4'd0, 4'd0, 1'b1);
        push(4'd1, 4'd1, 1'b1);
        case (op)
            OP_LW: begin
                push(4'd2, 4'd2, 1'b1);
                repeat (memStall) push(4'd3, 4'd3, 1'b0);
                push(4'd3, 4'd3, 1'b1);
                push(4'd4, 4'd4, 1'b1);
            end
            OP_SW: begin
                push(4'd2, 4'd2, 1'b1);
                repeat (memStall) push(4'd5, 4'd5, 1'b0);
                push(4'd5, 4'd5, 1'b1);
            end
            OP_RTYPE: begin push(4'd6, 4'd6, 1'b1); push(4'd7, 4'd7, 1'b1); end
            OP_BEQ:   push(4'd8, 4'd8, 1'b1);
            OP_J:     push(4'd9, 4'd9, 1'b1);
            OP_ADDI:  begin push(4'd10, 4'd10, 1'b1); push(4'd11, 4'd11, 1'b1); end
            default: ;
        endcase
        runQueue(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.stateH", {13'd0, hState}, 17'd0);
        check("reset.outsH", outsHalt, 17'd0);
        check("reset.outsS", outsSoft, 17'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        runInstr("lw", OP_LW, 0, 0);
        runInstr("lw_stall3", OP_LW, 0, 3);
        runInstr("rtype", OP_RTYPE, 0, 0);
        runInstr("beq", OP_BEQ, 0, 0);
        runInstr("j", OP_J, 0, 0);
        runInstr("addi", OP_ADDI, 0, 0);
        runInstr("sw", OP_SW, 0, 0);
        runInstr("lw_fetchstall2", OP_LW, 2, 1);
        runInstr("sw_stall2", OP_SW, 0, 2);

        // Undefined opcode: halting instance parks in HALT, the other keeps refetching.
        opcode = OP_BAD;
        push(4'd0, 4'd0, 1'b1);
        push(4'd1, 4'd1, 1'b1);
        for (int i = 0; i < 10; i++) push(4'd15, (i % 2 == 0) ? 4'd0 : 4'd1, 1'b1);
        runQueue("illegal");

        reset = 1'b1;
        #1;
        check("haltrst.stateH", {13'd0, hState}, 17'd0);
        check("haltrst.outsH", outsHalt, 17'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // sw stalled in MEM_WRITE, then reset pulsed between edges.
        opcode = OP_SW;
        push(4'd0, 4'd0, 1'b1);
        push(4'd1, 4'd1, 1'b1);
        push(4'd2, 4'd2, 1'b1);
        push(4'd5, 4'd5, 1'b0);
        push(4'd5, 4'd5, 1'b0);
        runQueue("sw_stalled");
        mem_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("midrst.stateH", {13'd0, hState}, 17'd0);
        check("midrst.outsH", outsHalt, 17'd0);
        check("midrst.stateS", {13'd0, sState}, 17'd0);
        check("midrst.outsS", outsSoft, 17'd0);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        runInstr("addi_after_rst", OP_ADDI, 0, 0);
        runInstr("j_final", OP_J, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
